// File: rtl/crr_div.sv
// crr_div: restoring shift-subtract unsigned divider, one quotient bit per clock.
// Define CRR_DIV_ZERO_CHK_EN to finish a divide-by-zero in one edge and flag it on div_zero.
module crr_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, part_q, part_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   shifted, trial;
    logic             last, zero_start;

    // The restored partial always stays below the divisor, so WIDTH bits hold it.
    assign shifted = {part_q, dvd_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign last    = cnt_q == CW'(WIDTH - 1);

`ifdef CRR_DIV_ZERO_CHK_EN
    logic div_zero_q, div_zero_d;
    assign zero_start = divisor == '0;
    assign div_zero   = div_zero_q;
`else
    assign zero_start = 1'b0;
    assign div_zero   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (start ? (zero_start ? DONE : RUN) : IDLE)
                : state_q == RUN  ? (last ? DONE : RUN)
                :                   IDLE;
    end

    always_comb begin
        busy = state_q != IDLE;
        done = state_q == DONE;
    end

    // Quotient bits enter the dividend register from the LSB as its MSBs are consumed.
    always_comb begin
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        part_d      = part_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef CRR_DIV_ZERO_CHK_EN
        div_zero_d  = div_zero_q;
`endif
        if (state_q == IDLE && start) begin
            dvd_d  = dividend;
            dvs_d  = divisor;
            part_d = '0;
            cnt_d  = '0;
`ifdef CRR_DIV_ZERO_CHK_EN
            if (zero_start) begin
                quotient_d  = '1;
                remainder_d = dividend;
                div_zero_d  = 1'b1;
            end
`endif
        end else if (state_q == RUN) begin
            part_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            dvd_d  = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
                quotient_d  = dvd_d;
                remainder_d = part_d;
`ifdef CRR_DIV_ZERO_CHK_EN
                div_zero_d  = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            part_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef CRR_DIV_ZERO_CHK_EN
            div_zero_q  <= 1'b0;
`endif
        end else begin
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            part_q      <= part_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef CRR_DIV_ZERO_CHK_EN
            div_zero_q  <= div_zero_d;
`endif
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
endmodule

// File: tb/tb_crr_div.sv
// tb_crr_div: randomized and directed checks of crr_div against an arithmetic reference model.
module tb_crr_div;
    localparam int W = 8;
`ifdef CRR_DIV_ZERO_CHK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;
    int           n_chk = 0, n_fail = 0;

    crr_div #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One division: operands scrambled after E0; poke re-asserts start mid-run.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        logic [W-1:0] eq, er;
        int el, lat, busy_n, done_n;
        eq = b == 0 ? '1 : a / b;
        er = b == 0 ? a : a % b;
        el = (ZC && b == 0) ? 1 : W + 1;
        lat = 0; busy_n = 0; done_n = 0;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1 start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (poke && i == 3) start = 1'b1;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                lat = i;
                start = 1'b0;
                chk("quotient", quotient, eq);
                chk("remainder", remainder, er);
                chk("div_zero", div_zero, ZC && b == 0);
                if (b != 0) chk("rem_lt_div", remainder < b, 1);
            end
            if (!busy) break;
        end
        start = 1'b0;
        chk("done_count", done_n, 1);
        chk("latency", lat, el);
        chk("busy_cycles", busy_n, el);
        chk("hold_quotient", quotient, eq);
        chk("hold_remainder", remainder, er);
    endtask

    initial begin
        int d_idx[$];
        int n_done;
        logic [W-1:0] a, b;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_zero", div_zero, 0);

        run(100, 7, 0);
        run(77, 0, 0);
        run(255, 1, 0);
        run(5, 9, 1);
        run(0, 3, 0);

        // start held high across two operations
        @(negedge clk);
        start = 1'b1; dividend = 200; divisor = 13;
        @(posedge clk);
        #1 dividend = 50; divisor = 6;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                d_idx.push_back(i);
                if (d_idx.size() == 1) begin
                    chk("held1_quotient", quotient, 15);
                    chk("held1_remainder", remainder, 5);
                end else begin
                    chk("held2_quotient", quotient, 8);
                    chk("held2_remainder", remainder, 2);
                    start = 1'b0;
                end
            end
            if (d_idx.size() >= 2 && !busy) break;
        end
        start = 1'b0;
        chk("held_done_count", d_idx.size(), 2);
        chk("held_spacing", d_idx.size() == 2 ? d_idx[1] - d_idx[0] : -1, W + 2);

        // reset during iteration 4
        @(negedge clk);
        start = 1'b1; dividend = 250; divisor = 3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_quotient", quotient, 0);
        chk("mid_rst_remainder", remainder, 0);
        chk("mid_rst_div_zero", div_zero, 0);
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("mid_rst_no_done", n_done, 0);
        run(250, 3, 0);

        for (int k = 0; k < 1000; k++) begin
            a = W'($urandom);
            b = W'($urandom_range(1, (1 << W) - 1));
            run(a, b, k % 7 == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
